// File: rtl/ram_stream_reader_pkg.sv
// ram_pkg: shared types and constants for the RAM stream reader.
//   state_e        : reader FSM states (IDLE, RUN, DONE)
//   addr_w()       : address width for a given RAM depth
//   OUT_FIFO_DEPTH : entries in the output skid FIFO
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OUT_FIFO_DEPTH = 32'sd2;

  // Address width for a RAM of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read and output stream signals of the
// RAM stream reader.
//   start/base_addr/len : transfer command (into the reader)
//   busy/done           : transfer status (from the reader)
//   rd_addr/rd_data     : RAM read port (address out, registered data in)
//   out_data/out_valid/out_ready : valid/ready output stream
//   csum                : running checksum, only with RAM_STREAM_READER_CSUM_EN
// modport master = the reader, modport slave = its environment.
interface ram_stream_reader_if
  import ram_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 16
) ();
  localparam int AW = addr_w(Depth);

  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      len;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rd_addr;
  logic [Width-1:0] rd_data;
  logic [Width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef RAM_STREAM_READER_CSUM_EN
  logic [Width-1:0] csum;

  modport master (
    input  start, base_addr, len, rd_data, out_ready,
    output busy, done, rd_addr, out_data, out_valid, csum
  );
  modport slave (
    output start, base_addr, len, rd_data, out_ready,
    input  busy, done, rd_addr, out_data, out_valid, csum
  );
`else
  modport master (
    input  start, base_addr, len, rd_data, out_ready,
    output busy, done, rd_addr, out_data, out_valid
  );
  modport slave (
    output start, base_addr, len, rd_data, out_ready,
    input  busy, done, rd_addr, out_data, out_valid
  );
`endif
endinterface

// File: rtl/ram_stream_reader_skid_fifo.sv
// ram_skid_fifo: 2-entry registered FIFO buffering RAM read data.
//   clk, rst    : clock, asynchronous active-high reset
//   push_i      : write push_data_i this cycle
//   pop_i       : remove the head entry this cycle
//   occ_o       : current occupancy (0..2)
//   head_o      : head entry, driven from storage registers only
module ram_skid_fifo
  import ram_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [Width-1:0] head_o
);
  localparam logic [1:0] OCC_FULL = 2'(OUT_FIFO_DEPTH);

  logic [Width-1:0] mem_q [OUT_FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s  = pop_i && (occ_q != 2'd0);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok_s = push_i && ((occ_q != OCC_FULL) || pop_ok_s);

  // Occupancy next state.
  always_comb begin
    occ_d = occ_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous RAM address range (wrapping modulo
// Depth), issues one read per cycle into a registered-read RAM and presents
// the words on a valid/ready stream with full backpressure.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ram_stream_reader_if.master (command, status, RAM read port,
//              output stream)
// Optional: define RAM_STREAM_READER_CSUM_EN to add bus.csum, the running
// sum modulo 2^Width of the words popped in the current transfer.
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                clk,
  input  logic                rst,
  ram_stream_reader_if.master bus
);
  localparam int            AW        = addr_w(Depth);
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(32'd1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(32'd1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(Depth - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      issue_cnt_q, issue_cnt_d;
  logic [AW:0]      pop_cnt_q, pop_cnt_d;
  logic             inflight_q, inflight_d;
  logic             busy_q, done_q;
  logic [1:0]       occ_s;
  logic [Width-1:0] head_s;
  logic             out_valid_s;
  logic             pop_s;
  logic             issue_s;
  logic [2:0]       fill_s;
  logic [AW-1:0]    addr_nxt_s;

  assign out_valid_s = (occ_s != 2'd0);
  assign pop_s       = out_valid_s && bus.out_ready;
  // Words already buffered or on their way, after this cycle's pop. Keeping
  // this below the FIFO depth is what rules out overflow.
  assign fill_s      = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s     = (state_q == RUN) && (issue_cnt_q != CNT_ZERO) &&
                       (fill_s < 3'(OUT_FIFO_DEPTH));
  assign addr_nxt_s  = (addr_q == ADDR_LAST) ? ADDR_ZERO : (addr_q + ADDR_ONE);

  // FSM next state, read issue and counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    inflight_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != CNT_ZERO) begin
            addr_d      = bus.base_addr;
            issue_cnt_d = bus.len;
            pop_cnt_d   = bus.len;
            state_d     = RUN;
          end else begin
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_s) begin
          addr_d      = addr_nxt_s;
          issue_cnt_d = issue_cnt_q - CNT_ONE;
          inflight_d  = 1'b1;
        end else begin
          inflight_d  = 1'b0;
        end
        if (pop_s) begin
          pop_cnt_d = pop_cnt_q - CNT_ONE;
          if (pop_cnt_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= ADDR_ZERO;
      issue_cnt_q <= CNT_ZERO;
      pop_cnt_q   <= CNT_ZERO;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  // RAM data arrives the cycle after the issue, tracked by inflight_q.
  ram_skid_fifo #(
    .Width(Width)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.rd_data),
    .pop_i       (pop_s),
    .occ_o       (occ_s),
    .head_o      (head_s)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = head_s;

`ifdef RAM_STREAM_READER_CSUM_EN
  logic [Width-1:0] csum_q, csum_d;

  // Checksum next value: cleared by an accepted start, accumulates pops.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && bus.start) begin
      csum_d = '0;
    end else if (pop_s) begin
      csum_d = csum_q + head_s;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register; holds its value after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.csum = csum_q;
`endif

endmodule
